// File: rtl/mul_out_stage.sv
// Output stage of the pipelined multiplier: 2-entry skid buffer between the
// pipeline and the consumer, plus sticky exception flags and a saturating count.
module mul_out_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [4:0]       in_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_status,
  input  logic             flags_clr,
  output logic [4:0]       flags,
  output logic [CNT_W-1:0] exc_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [4:0]       status;
  } entry_t;

  // Encoding is {main_valid, skid_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic [4:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  entry_t           in_entry;
  logic             accept, retire;
  logic [4:0]       flags_base;
  logic [CNT_W-1:0] cnt_base;

  assign in_entry   = '{result: in_result, status: in_status};
  assign in_ready   = !rst && !state_q[0];
  assign out_valid  = state_q[1];
  assign out_result = main_q.result;
  assign out_status = main_q.status;
  assign flags      = flags_q;
  assign exc_cnt    = cnt_q;

  assign accept = in_valid && in_ready;
  assign retire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && retire) begin
          main_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = FULL;
        end else if (retire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (retire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // A clear wipes history only; an item retiring in the same cycle still counts.
  always_comb begin
    flags_base = flags_clr ? 5'b0 : flags_q;
    cnt_base   = flags_clr ? '0 : cnt_q;
    flags_d    = flags_base;
    cnt_d      = cnt_base;
    if (retire) begin
      flags_d = flags_base | main_q.status;
      if ((main_q.status != 5'b0) && (cnt_base != CNT_MAX))
        cnt_d = cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mul_out_stage.sv
// Scoreboard bench for mul_out_stage: accepted items are queued, retired items
// are popped and compared; flags/counter checked against hand-derived values.
module tb_mul_out_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, flags_clr;
  logic [31:0] in_result, out_result;
  logic [4:0]  in_status, out_status, flags;
  logic [15:0] exc_cnt;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [31:0] out_result2;
  logic [4:0]  out_status2, flags2;
  logic [1:0]  exc_cnt2;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  s;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    retired = 0;

  always #5 clk = ~clk;

  mul_out_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_status(in_status),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_status(out_status),
    .flags_clr(flags_clr), .flags(flags), .exc_cnt(exc_cnt)
  );

  mul_out_stage #(.WIDTH(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_result(32'h4000_0000), .in_status(5'b00001),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_result(out_result2), .out_status(out_status2),
    .flags_clr(1'b0), .flags(flags2), .exc_cnt(exc_cnt2)
  );

  // Inputs change just after posedge, so at negedge we see exactly the
  // handshakes that will complete on the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        item_t exp_item;
        checks++;
        retired++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL retire_unexpected: got %h/%b, expected no output", out_result, out_status);
        end else begin
          exp_item = sb.pop_front();
          if ({out_result, out_status} !== exp_item) begin
            errors++;
            $display("FAIL retire_data: got %h/%b, expected %h/%b",
                     out_result, out_status, exp_item.r, exp_item.s);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back('{r: in_result, s: in_status});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d items left, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flags_clr = 1'b0;
    in_result = '0; in_status = '0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    step(); step();
    checks++;
    if ({out_valid, out_result, out_status, flags, exc_cnt, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b r=%h s=%b f=%b c=%0d rdy=%b, expected all 0",
               out_valid, out_result, out_status, flags, exc_cnt, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_result = 32'h3F80_0000; in_status = 5'b00001; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h3F80_0000 || out_status !== 5'b00001) begin
      errors++;
      $display("FAIL single_latency: got v=%b %h/%b, expected 1 3f800000/00001",
               out_valid, out_result, out_status);
    end
    step();
    checks++;
    if (flags !== 5'b00001 || exc_cnt !== 16'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_flags: got f=%b c=%0d v=%b, expected 00001 1 0", flags, exc_cnt, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int r0 = retired;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_result = $urandom; in_status = 5'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready: item %0d got %b, expected 1", i, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (retired - r0 != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_rate: got %0d retires, %0d queued, expected 8 and 0", retired - r0, sb.size());
    end
  endtask

  task automatic test_stall();
    int r0 = retired;
    logic [31:0] first = 32'hA000_0001;
    out_ready = 1'b0; in_valid = 1'b1;
    in_result = first; in_status = '0; step();
    in_result = 32'hA000_0002; step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== first) begin
      errors++;
      $display("FAIL stall_full: got rdy=%b v=%b r=%h, expected 0 1 %h", in_ready, out_valid, out_result, first);
    end
    in_result = 32'hA000_0003; step(); step();
    checks++;
    if (in_ready !== 1'b0 || out_result !== first || out_status !== 5'b0) begin
      errors++;
      $display("FAIL stall_stable: got rdy=%b r=%h, expected 0 %h", in_ready, out_result, first);
    end
    out_ready = 1'b1;
    while (!in_ready) step();
    step();
    in_valid = 1'b0;
    drain();
    step();
    checks++;
    if (retired - r0 != 3 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_count: got %0d retires v=%b, expected 3 0", retired - r0, out_valid);
    end
  endtask

  task automatic test_flags();
    flags_clr = 1'b1; step(); flags_clr = 1'b0;
    checks++;
    if (flags !== 5'b0 || exc_cnt !== 16'd0) begin
      errors++;
      $display("FAIL flags_clr_idle: got f=%b c=%0d, expected 00000 0", flags, exc_cnt);
    end
    out_ready = 1'b1; in_valid = 1'b1;
    in_result = 32'h1; in_status = 5'b10000; step();
    in_result = 32'h2; in_status = 5'b00100; step();
    in_result = 32'h3; in_status = 5'b00000; step();
    in_valid = 1'b0;
    drain();
    checks++;
    if (flags !== 5'b10100 || exc_cnt !== 16'd2) begin
      errors++;
      $display("FAIL flags_accum: got f=%b c=%0d, expected 10100 2", flags, exc_cnt);
    end
    in_valid = 1'b1; in_result = 32'h4; in_status = 5'b00010; out_ready = 1'b0; step();
    in_valid = 1'b0;
    checks++;
    if (flags !== 5'b10100 || exc_cnt !== 16'd2) begin
      errors++;
      $display("FAIL flags_on_accept: got f=%b c=%0d, expected 10100 2", flags, exc_cnt);
    end
    flags_clr = 1'b1; out_ready = 1'b1; step();
    flags_clr = 1'b0;
    checks++;
    if (flags !== 5'b00010 || exc_cnt !== 16'd1) begin
      errors++;
      $display("FAIL flags_clr_retire: got f=%b c=%0d, expected 00010 1", flags, exc_cnt);
    end
  endtask

  task automatic test_saturate();
    out_ready2 = 1'b1; in_valid2 = 1'b1;
    repeat (5) step();
    in_valid2 = 1'b0;
    step();
    checks++;
    if (exc_cnt2 !== 2'd3 || flags2 !== 5'b00001 || out_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL saturate: got c=%0d f=%b v=%b, expected 3 00001 0", exc_cnt2, flags2, out_valid2);
    end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0; in_valid = 1'b1;
    in_result = 32'hDEAD_0001; in_status = 5'b00100; step();
    in_result = 32'hDEAD_0002; in_status = 5'b10000; step();
    in_valid = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || flags !== 5'b0 || exc_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_full: got v=%b rdy=%b f=%b c=%0d, expected 0 1 00000 0",
               out_valid, in_ready, flags, exc_cnt);
    end
    out_ready = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_discard: got out_valid=%b r=%h, expected 0", out_valid, out_result);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flags();
    test_saturate();
    test_reset_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
